gpio_controller: RTL and testbench

- Memory-mapped GPIO port on the processor data bus.
- Holds the output pin register and a 2-FF synchronizer plus per-pin debouncer on the input pins.
- Latches rising edges of debounced inputs into a write-1-to-clear interrupt status register, and raises IRQ to the core.

---
 rtl/gpio_controller_pkg.sv | 11 +
 rtl/gpio_debounce.sv | 43 ++++
 rtl/gpio_controller.sv | 79 +++++++
 tb/tb_gpio_controller.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_controller_pkg.sv
// Shared definitions for the GPIO controller: bus width and register map.
package gpio_controller_pkg;

  localparam int GPIO_BUS_W = 32;

  localparam logic [1:0] GPIO_ADDR_OUT        = 2'd0;
  localparam logic [1:0] GPIO_ADDR_IN         = 2'd1;
  localparam logic [1:0] GPIO_ADDR_IRQ_STATUS = 2'd2;
  localparam logic [1:0] GPIO_ADDR_IRQ_EN     = 2'd3;

endpackage

// File: rtl/gpio_debounce.sv
// One input pin: 2-FF synchronizer, stability counter, debounced level and
// a rising-edge strobe that is high in the cycle before deb goes 0->1.
module gpio_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic pin,
  output logic deb,
  output logic rise
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      deb   <= 1'b0;
    end else begin
      sync1 <= pin;
      sync2 <= sync1;
      // Any return to the accepted level restarts the stability count.
      if (sync2 == deb) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        deb <= sync2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign rise = sync2 & ~deb & (cnt == CNT_LAST);

endmodule

// File: rtl/gpio_controller.sv
// Memory-mapped GPIO port: output register, debounced inputs, and
// rising-edge interrupt status (write-1-to-clear) with per-pin enable.
module gpio_controller
  import gpio_controller_pkg::*;
#(
  parameter int GPIO_WIDTH      = 8,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [1:0]            ADDR,
  input  logic                  WE,
  input  logic [GPIO_BUS_W-1:0] WD,
  output logic [GPIO_BUS_W-1:0] RD,
  input  logic [GPIO_WIDTH-1:0] PINS_IN,
  output logic [GPIO_WIDTH-1:0] PINS_OUT,
  output logic                  IRQ
);

  logic [GPIO_WIDTH-1:0] out_reg;
  logic [GPIO_WIDTH-1:0] irq_status;
  logic [GPIO_WIDTH-1:0] irq_en;
  logic [GPIO_WIDTH-1:0] deb;
  logic [GPIO_WIDTH-1:0] rise;
  logic [GPIO_WIDTH-1:0] wd_pins;
  logic [GPIO_WIDTH-1:0] w1c_mask;
  logic                  unused_wd;

  assign wd_pins   = WD[GPIO_WIDTH-1:0];
  assign unused_wd = ^WD;

  for (genvar i = 0; i < GPIO_WIDTH; i++) begin : g_pin
    gpio_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_debounce (
      .CLK   (CLK),
      .RST_N (RST_N),
      .pin   (PINS_IN[i]),
      .deb   (deb[i]),
      .rise  (rise[i])
    );
  end

  assign w1c_mask = (WE && (ADDR == GPIO_ADDR_IRQ_STATUS)) ? wd_pins : '0;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      out_reg    <= '0;
      irq_en     <= '0;
      irq_status <= '0;
    end else begin
      if (WE && (ADDR == GPIO_ADDR_OUT)) begin
        out_reg <= wd_pins;
      end
      if (WE && (ADDR == GPIO_ADDR_IRQ_EN)) begin
        irq_en <= wd_pins;
      end
      // A new edge outranks a clear landing on the same cycle.
      irq_status <= (irq_status & ~w1c_mask) | rise;
    end
  end

  always_comb begin
    RD = '0;
    case (ADDR)
      GPIO_ADDR_OUT:        RD = GPIO_BUS_W'(out_reg);
      GPIO_ADDR_IN:         RD = GPIO_BUS_W'(deb);
      GPIO_ADDR_IRQ_STATUS: RD = GPIO_BUS_W'(irq_status);
      GPIO_ADDR_IRQ_EN:     RD = GPIO_BUS_W'(irq_en);
      default:              RD = '0;
    endcase
  end

  assign PINS_OUT = out_reg;
  assign IRQ      = |(irq_status & irq_en);

endmodule

// File: tb/tb_gpio_controller.sv
// Directed bench for gpio_controller with a queue-based scoreboard and monitor.
module tb_gpio_controller;

  localparam int GW = 8;

  logic          CLK;
  logic          RST_N;
  logic [1:0]    ADDR;
  logic          WE;
  logic [31:0]   WD;
  logic [31:0]   RD;
  logic [GW-1:0] PINS_IN;
  logic [GW-1:0] PINS_OUT;
  logic          IRQ;

  gpio_controller #(
    .GPIO_WIDTH      (GW),
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (8)
  ) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .ADDR     (ADDR),
    .WE       (WE),
    .WD       (WD),
    .RD       (RD),
    .PINS_IN  (PINS_IN),
    .PINS_OUT (PINS_OUT),
    .IRQ      (IRQ)
  );

  initial CLK = 1'b0;
  always #10 CLK = ~CLK;

  localparam int K_RD   = 0;
  localparam int K_PINS = 1;
  localparam int K_IRQ  = 2;

  typedef struct {
    string       name;
    int          kind;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  event sample_ev;
  int   checks = 0;
  int   errors = 0;

  // Monitor: whenever the stimulus flags that outputs are settled, drain the
  // expectation queue against what the DUT is presenting.
  initial begin
    exp_t        e;
    logic [31:0] act;
    forever begin
      @(sample_ev);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        case (e.kind)
          K_PINS:  act = {24'h0, PINS_OUT};
          K_IRQ:   act = {31'h0, IRQ};
          default: act = RD;
        endcase
        checks++;
        if (act !== e.exp) begin
          errors++;
          $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    ADDR = a;
    WE   = 1'b1;
    WD   = d;
    tick();
    WE   = 1'b0;
    WD   = '0;
  endtask

  task automatic chk(input string name, input int kind, input logic [1:0] a,
                     input logic [31:0] v);
    exp_t e;
    if (kind == K_RD) ADDR = a;
    #1;
    e.name = name;
    e.kind = kind;
    e.exp  = v;
    sb.push_back(e);
    ->sample_ev;
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    RST_N   = 1'b0;
    ADDR    = 2'd0;
    WE      = 1'b0;
    WD      = '0;
    PINS_IN = 8'hFF;
    ticks(3);

    // Reset defaults while held
    chk("rst_pins_out", K_PINS, 2'd0, 32'h0);
    chk("rst_irq",      K_IRQ,  2'd0, 32'h0);
    chk("rst_rd0",      K_RD,   2'd0, 32'h0);
    chk("rst_rd1",      K_RD,   2'd1, 32'h0);
    chk("rst_rd2",      K_RD,   2'd2, 32'h0);
    chk("rst_rd3",      K_RD,   2'd3, 32'h0);

    // Release: inputs appear at RD(1) exactly 6 edges later
    RST_N = 1'b1;
    ticks(5);
    chk("rel_in_edge5", K_RD, 2'd1, 32'h0);
    tick();
    chk("rel_in_edge6", K_RD, 2'd1, 32'hFF);
    chk("rel_status",   K_RD, 2'd2, 32'hFF);
    chk("rel_irq_off",  K_IRQ, 2'd0, 32'h0);
    wr(2'd2, 32'hFF);
    chk("w1c_all", K_RD, 2'd2, 32'h0);

    // Output register, upper write bits ignored; IN is read-only
    wr(2'd0, 32'hFFFF_FFA5);
    chk("out_pins", K_PINS, 2'd0, 32'hA5);
    chk("out_rd0",  K_RD,   2'd0, 32'h0000_00A5);
    wr(2'd1, 32'h0000_0000);
    chk("in_ro",    K_RD,   2'd1, 32'hFF);

    // Falling inputs are debounced but never captured
    PINS_IN = 8'h00;
    ticks(8);
    chk("fall_in",     K_RD, 2'd1, 32'h0);
    chk("fall_status", K_RD, 2'd2, 32'h0);

    // 3-cycle glitch on pin 0 is rejected
    PINS_IN = 8'h01;
    ticks(3);
    PINS_IN = 8'h00;
    ticks(8);
    chk("glitch_in",     K_RD, 2'd1, 32'h0);
    chk("glitch_status", K_RD, 2'd2, 32'h0);

    // 6-cycle pulse on pin 0 is accepted at edge k+5
    PINS_IN = 8'h01;
    ticks(5);
    chk("pulse_in_k4",     K_RD, 2'd1, 32'h0);
    chk("pulse_status_k4", K_RD, 2'd2, 32'h0);
    tick();
    chk("pulse_in_k5",     K_RD, 2'd1, 32'h01);
    chk("pulse_status_k5", K_RD, 2'd2, 32'h01);
    PINS_IN = 8'h00;

    // IRQ gating by enable and clearing
    chk("gate_irq_dis", K_IRQ, 2'd0, 32'h0);
    wr(2'd3, 32'h01);
    chk("gate_irq_en",  K_IRQ, 2'd0, 32'h1);
    chk("gate_en_rd",   K_RD,  2'd3, 32'h01);
    wr(2'd2, 32'h01);
    chk("gate_w1c",     K_RD,  2'd2, 32'h0);
    chk("gate_irq_clr", K_IRQ, 2'd0, 32'h0);
    ticks(8);
    chk("gate_nofall",  K_RD,  2'd2, 32'h0);

    // Set wins over a same-edge clear of bit 3
    PINS_IN = 8'h08;
    ticks(5);
    ADDR = 2'd2;
    WE   = 1'b1;
    WD   = 32'h08;
    tick();
    WE   = 1'b0;
    WD   = '0;
    chk("setwin_status", K_RD,  2'd2, 32'h08);
    chk("setwin_in",     K_RD,  2'd1, 32'h08);
    chk("setwin_irq",    K_IRQ, 2'd0, 32'h0);
    wr(2'd3, 32'hFF);
    chk("allen_irq",     K_IRQ, 2'd0, 32'h1);

    // Async reset mid-debounce on pin 2 (cnt=2), no clock edge involved
    PINS_IN = 8'h0C;
    ticks(4);
    #3;
    RST_N   = 1'b0;
    PINS_IN = 8'h04;
    chk("async_status", K_RD,   2'd2, 32'h0);
    chk("async_en",     K_RD,   2'd3, 32'h0);
    chk("async_irq",    K_IRQ,  2'd0, 32'h0);
    chk("async_in",     K_RD,   2'd1, 32'h0);
    chk("async_out",    K_PINS, 2'd0, 32'h0);
    RST_N = 1'b1;

    // Pin 2 must be debounced from scratch: full 6 edges after release
    ticks(5);
    chk("after_in_edge5",     K_RD, 2'd1, 32'h0);
    chk("after_status_edge5", K_RD, 2'd2, 32'h0);
    tick();
    chk("after_in_edge6",     K_RD,  2'd1, 32'h04);
    chk("after_status_edge6", K_RD,  2'd2, 32'h04);
    chk("after_irq",          K_IRQ, 2'd0, 32'h0);

    // Partial W1C leaves other bits alone
    wr(2'd2, 32'hFB);
    chk("w1c_other", K_RD, 2'd2, 32'h04);
    wr(2'd2, 32'h04);
    chk("w1c_bit2",  K_RD, 2'd2, 32'h0);

    tick();
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
